// File: rtl/qc_ldpc_pkg.sv
// Shared constants and FSM encoding for the QC-LDPC codeword serializer.
package qc_ldpc_pkg;

  localparam int unsigned INFO_LEN        = 2127;
  localparam int unsigned CIRC_SIZE       = 88;
  localparam int unsigned NUM_PARITY_CIRC = 16;
  localparam int unsigned PAR_LEN         = CIRC_SIZE * NUM_PARITY_CIRC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFO     = 2'd1,
    ST_WAIT_PAR = 2'd2,
    ST_PARITY   = 2'd3
  } ser_state_t;

endpackage

// File: rtl/qc_ldpc_piso_shift_reg.sv
// Parallel-in / serial-out shift register: parallel load, enable-gated
// left shift, MSB presented as the serial output.
module qc_ldpc_piso_shift_reg #(
  parameter int unsigned WIDTH = qc_ldpc_pkg::PAR_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             msb_out
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next value: load has priority over shift.
  always_comb begin
    shift_d = shift_q;
    if (load_en) begin
      shift_d = load_data;
    end else if (shift_en) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign msb_out = shift_q[WIDTH-1];

endmodule

// File: rtl/qc_ldpc_codeword_serializer.sv
// QC-LDPC codeword serializer: forwards INFO_LEN systematic bits (latency 1,
// no backpressure), then shifts out the captured PAR_LEN-bit parity vector
// MSB first under a valid/ready handshake.
// Optional feature macro: QC_LDPC_SER_FRAME_FLAGS_EN (out_sop/out_eop ports
// and the stray-info-beat check).
module qc_ldpc_codeword_serializer #(
  parameter int unsigned INFO_LEN        = qc_ldpc_pkg::INFO_LEN,
  parameter int unsigned CIRC_SIZE       = qc_ldpc_pkg::CIRC_SIZE,
  parameter int unsigned NUM_PARITY_CIRC = qc_ldpc_pkg::NUM_PARITY_CIRC
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_in,
  input  logic                                  info_bit_in,
  input  logic                                  info_valid_in,
  input  logic [CIRC_SIZE*NUM_PARITY_CIRC-1:0]  parity_vector_in,
  input  logic                                  parity_done_in,
  output logic                                  out_bit,
  output logic                                  out_valid,
  input  logic                                  out_ready,
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
  output logic                                  out_sop,
  output logic                                  out_eop,
`endif
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  err_sticky
);

  import qc_ldpc_pkg::ser_state_t;
  import qc_ldpc_pkg::ST_IDLE;
  import qc_ldpc_pkg::ST_INFO;
  import qc_ldpc_pkg::ST_WAIT_PAR;
  import qc_ldpc_pkg::ST_PARITY;

  localparam int unsigned PAR_LEN = CIRC_SIZE * NUM_PARITY_CIRC;
  localparam int unsigned INFO_CW = $clog2(INFO_LEN + 1);
  localparam int unsigned PAR_CW  = $clog2(PAR_LEN + 1);
  localparam logic [INFO_CW-1:0] INFO_LAST = INFO_CW'(INFO_LEN - 1);
  localparam logic [PAR_CW-1:0]  PAR_LAST  = PAR_CW'(PAR_LEN - 1);

  ser_state_t         state_q, state_d;
  logic [INFO_CW-1:0] info_cnt_q, info_cnt_d;
  logic [PAR_CW-1:0]  par_cnt_q, par_cnt_d;
  logic               info_bit_q, info_bit_d;
  logic               info_valid_q, info_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
  logic               sop_q, sop_d;
`endif

  logic load_en;
  logic shift_en;
  logic par_msb;
  logic par_active;
  logic par_accept;
  logic info_beat;
  logic info_last;

  // The last info bit is still on the output during the first cycle after
  // leaving INFO; parity output is held off until that beat has gone out.
  assign par_active = (state_q == ST_PARITY) && !info_valid_q;
  assign par_accept = par_active && out_ready;
  assign info_beat  = (state_q == ST_INFO) && info_valid_in;
  assign info_last  = info_beat && (info_cnt_q == INFO_LAST);

  // Next-state, counter and error-flag logic.
  always_comb begin
    state_d      = state_q;
    info_cnt_d   = info_cnt_q;
    par_cnt_d    = par_cnt_q;
    info_bit_d   = info_bit_q;
    info_valid_d = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    load_en      = 1'b0;
    shift_en     = 1'b0;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    sop_d        = 1'b0;
`endif

    // Info beats cannot be stalled; a refused one is still counted as sent.
    if (info_valid_q && !out_ready) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (parity_done_in) begin
          err_d = 1'b1;
        end
        // The frame_done cycle still belongs to the finishing frame.
        if (start_in) begin
          if (frame_done_q) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_INFO;
            info_cnt_d = '0;
          end
        end
      end

      ST_INFO: begin
        if (start_in) begin
          err_d = 1'b1;
        end
        if (info_beat) begin
          info_bit_d   = info_bit_in;
          info_valid_d = 1'b1;
          info_cnt_d   = info_cnt_q + INFO_CW'(1);
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
          sop_d        = (info_cnt_q == '0);
`endif
        end
        if (info_last) begin
          if (parity_done_in) begin
            load_en   = 1'b1;
            par_cnt_d = '0;
            state_d   = ST_PARITY;
          end else begin
            state_d   = ST_WAIT_PAR;
          end
        end else if (parity_done_in) begin
          err_d = 1'b1;
        end
      end

      ST_WAIT_PAR: begin
        if (start_in) begin
          err_d = 1'b1;
        end
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
        if (info_valid_in) begin
          err_d = 1'b1;
        end
`endif
        if (parity_done_in) begin
          load_en   = 1'b1;
          par_cnt_d = '0;
          state_d   = ST_PARITY;
        end
      end

      ST_PARITY: begin
        if (start_in || parity_done_in) begin
          err_d = 1'b1;
        end
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
        if (info_valid_in) begin
          err_d = 1'b1;
        end
`endif
        if (par_accept) begin
          shift_en  = 1'b1;
          par_cnt_d = par_cnt_q + PAR_CW'(1);
          if (par_cnt_q == PAR_LAST) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      info_cnt_q   <= '0;
      par_cnt_q    <= '0;
      info_bit_q   <= 1'b0;
      info_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
      sop_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      info_cnt_q   <= info_cnt_d;
      par_cnt_q    <= par_cnt_d;
      info_bit_q   <= info_bit_d;
      info_valid_q <= info_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
      sop_q        <= sop_d;
`endif
    end
  end

  qc_ldpc_piso_shift_reg #(
    .WIDTH (PAR_LEN)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (parity_vector_in),
    .shift_en  (shift_en),
    .msb_out   (par_msb)
  );

  assign out_valid  = info_valid_q | par_active;
  assign out_bit    = par_active ? par_msb : (info_bit_q & info_valid_q);
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_sticky = err_q;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
  assign out_sop    = sop_q;
  assign out_eop    = par_active && (par_cnt_q == PAR_LAST);
`endif

endmodule

// File: tb/tb_qc_ldpc_codeword_serializer.sv
// Bench for qc_ldpc_codeword_serializer: a small instance (8 info + 8 parity
// bits) for the directed/random scenarios and one full-size instance.
module tb_qc_ldpc_codeword_serializer;

  localparam int S_INFO = 8;
  localparam int S_PAR  = 8;
  localparam int F_INFO = 2127;
  localparam int F_PAR  = 1408;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- small instance ----------------
  logic             s_reset = 1'b1, s_start = 1'b0, s_info_bit = 1'b0, s_info_valid = 1'b0;
  logic [S_PAR-1:0] s_pvec = '0;
  logic             s_pdone = 1'b0, s_out_ready = 1'b1;
  logic             s_out_bit, s_out_valid, s_frame_done, s_busy, s_err;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
  logic             s_sop, s_eop;
`endif

  qc_ldpc_codeword_serializer #(
    .INFO_LEN        (8),
    .CIRC_SIZE       (4),
    .NUM_PARITY_CIRC (2)
  ) u_small (
    .clk              (clk),
    .reset            (s_reset),
    .start_in         (s_start),
    .info_bit_in      (s_info_bit),
    .info_valid_in    (s_info_valid),
    .parity_vector_in (s_pvec),
    .parity_done_in   (s_pdone),
    .out_bit          (s_out_bit),
    .out_valid        (s_out_valid),
    .out_ready        (s_out_ready),
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    .out_sop          (s_sop),
    .out_eop          (s_eop),
`endif
    .frame_done       (s_frame_done),
    .busy             (s_busy),
    .err_sticky       (s_err)
  );

  // ---------------- full-size instance ----------------
  logic             f_reset = 1'b1, f_start = 1'b0, f_info_bit = 1'b0, f_info_valid = 1'b0;
  logic [F_PAR-1:0] f_pvec = '0;
  logic             f_pdone = 1'b0, f_out_ready = 1'b1;
  logic             f_out_bit, f_out_valid, f_frame_done, f_busy, f_err;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
  logic             f_sop, f_eop;
`endif

  qc_ldpc_codeword_serializer u_full (
    .clk              (clk),
    .reset            (f_reset),
    .start_in         (f_start),
    .info_bit_in      (f_info_bit),
    .info_valid_in    (f_info_valid),
    .parity_vector_in (f_pvec),
    .parity_done_in   (f_pdone),
    .out_bit          (f_out_bit),
    .out_valid        (f_out_valid),
    .out_ready        (f_out_ready),
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    .out_sop          (f_sop),
    .out_eop          (f_eop),
`endif
    .frame_done       (f_frame_done),
    .busy             (f_busy),
    .err_sticky       (f_err)
  );

  // Observation state for the small instance.
  logic s_got[$];
  int   s_acc_cyc[$];
  int   s_cyc = 0;
  int   s_fd_cnt = 0, s_fd_cyc = -1, s_fd_size = -1;
  logic s_fd_busy = 1'b1;
  int   s_sop_idx = -1, s_eop_idx = -1;

  // Observation state for the full instance.
  logic f_got[$];
  int   f_fd_cnt = 0;
  int   f_sop_idx = -1, f_eop_idx = -1;

  // One small-instance cycle: drive at negedge, observe 1 time unit later.
  task automatic cyc_s(input logic rst, input logic st, input logic ib, input logic iv,
                       input logic [S_PAR-1:0] pv, input logic pd, input logic rdy);
    @(negedge clk);
    s_reset = rst; s_start = st; s_info_bit = ib; s_info_valid = iv;
    s_pvec = pv; s_pdone = pd; s_out_ready = rdy;
    #1;
    s_cyc++;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    if (s_out_valid && s_sop) s_sop_idx = s_got.size();
    if (s_out_valid && s_eop) s_eop_idx = s_got.size();
`endif
    if (s_out_valid && s_out_ready) begin
      s_got.push_back(s_out_bit);
      s_acc_cyc.push_back(s_cyc);
    end
    if (s_frame_done) begin
      s_fd_cnt++;
      s_fd_cyc  = s_cyc;
      s_fd_size = s_got.size();
      s_fd_busy = s_busy;
    end
  endtask

  task automatic cyc_f(input logic st, input logic ib, input logic iv, input logic pd, input logic rdy);
    @(negedge clk);
    f_reset = 1'b0; f_start = st; f_info_bit = ib; f_info_valid = iv;
    f_pdone = pd; f_out_ready = rdy;
    #1;
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    if (f_out_valid && f_sop) f_sop_idx = f_got.size();
    if (f_out_valid && f_eop) f_eop_idx = f_got.size();
`endif
    if (f_out_valid && f_out_ready) f_got.push_back(f_out_bit);
    if (f_frame_done) f_fd_cnt++;
  endtask

  // Collected small-instance stream packed first-bit-MSB; missing bits read 0.
  function automatic logic [15:0] pack16();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[14:0], (i < s_got.size()) ? s_got[i] : 1'b0};
    return r;
  endfunction

  // Drive one small frame. done_mode: 0 done after info, 1 extra early done
  // (with a wrong vector) at info bit 3, 2 done coincident with info bit 8.
  // reset_at >= 0 asserts reset once that many parity bits have been taken.
  task automatic drive_frame_s(input logic [7:0] info, input logic [7:0] par, input int done_mode,
                               input bit use_bp, input bit gaps, input int reset_at);
    logic [3:0] pat;
    logic       pd, rdy;
    logic [7:0] pv;
    int         k;
    pat = 4'b1001;
    k   = 0;
    s_got.delete(); s_acc_cyc.delete();
    s_fd_cnt = 0; s_fd_cyc = -1; s_fd_size = -1; s_fd_busy = 1'b1;
    s_sop_idx = -1; s_eop_idx = -1;
    cyc_s(0, 1, 0, 0, '0, 0, 1);
    for (int i = 0; i < S_INFO; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc_s(0, 0, 0, 0, '0, 0, 1);
      pd = (done_mode == 2 && i == 7) || (done_mode == 1 && i == 3);
      pv = (done_mode == 1 && i == 3) ? ~par : par;
      cyc_s(0, 0, info[7-i], 1, pv, pd, 1);
    end
    if (done_mode != 2) begin
      cyc_s(0, 0, 0, 0, '0, 0, 1);
      cyc_s(0, 0, 0, 0, par, 1, 1);
    end
    for (int n = 0; n < 200 && s_fd_cnt == 0; n++) begin
      if (reset_at >= 0 && s_got.size() == S_INFO + reset_at) begin
        cyc_s(1, 0, 0, 0, '0, 0, 1);
        return;
      end
      if (!use_bp || s_got.size() < S_INFO) begin
        rdy = 1'b1;
      end else begin
        rdy = pat[k % 4];
        k++;
      end
      cyc_s(0, 0, 0, 0, '0, 0, rdy);
    end
  endtask

  task automatic test_reset();
    repeat (2) cyc_s(1, 0, 0, 0, '0, 0, 1);
    f_reset = 1'b0;
    cyc_s(0, 0, 0, 0, '0, 0, 1);
    checks++;
    if ({s_out_valid, s_out_bit, s_frame_done, s_busy, s_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_small outputs {valid,bit,done,busy,err}=%b expected 00000",
               {s_out_valid, s_out_bit, s_frame_done, s_busy, s_err});
    end
    checks++;
    if ({f_out_valid, f_out_bit, f_frame_done, f_busy, f_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_full outputs {valid,bit,done,busy,err}=%b expected 00000",
               {f_out_valid, f_out_bit, f_frame_done, f_busy, f_err});
    end
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    checks++;
    if ({s_sop, s_eop} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags sop/eop=%b expected 00", {s_sop, s_eop});
    end
`endif
  endtask

  task automatic test_nominal();
    drive_frame_s(8'b1011_0010, 8'hC5, 0, 0, 0, -1);
    checks++;
    if (s_got.size() != 16 || pack16() !== 16'b1011_0010_1100_0101) begin
      errors++;
      $display("FAIL nominal_stream got %b (%0d bits) expected 1011001011000101 (16 bits)",
               pack16(), s_got.size());
    end
    checks++;
    if (s_fd_cnt != 1 || s_fd_size != 16 || s_acc_cyc.size() != 16 || s_fd_cyc != s_acc_cyc[15] + 1) begin
      errors++;
      $display("FAIL nominal_frame_done count %0d at bit %0d cycle %0d expected 1 pulse one cycle after bit 16",
               s_fd_cnt, s_fd_size, s_fd_cyc);
    end
    checks++;
    if (s_fd_busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy busy=%b at frame_done expected 0", s_fd_busy);
    end
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_err err_sticky=%b expected 0", s_err);
    end
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    checks++;
    if (s_sop_idx != 0 || s_eop_idx != 15) begin
      errors++;
      $display("FAIL nominal_flags sop at %0d eop at %0d expected 0 and 15", s_sop_idx, s_eop_idx);
    end
`endif
  endtask

  task automatic test_backpressure();
    drive_frame_s(8'b1011_0010, 8'hC5, 0, 1, 0, -1);
    checks++;
    if (s_got.size() != 16 || pack16() !== 16'b1011_0010_1100_0101) begin
      errors++;
      $display("FAIL bp_stream got %b (%0d bits) expected 1011001011000101", pack16(), s_got.size());
    end
    checks++;
    if (s_acc_cyc.size() != 16 || s_acc_cyc[15] - s_acc_cyc[8] < 12) begin
      errors++;
      $display("FAIL bp_stall parity accept span %0d cycles expected at least 12",
               (s_acc_cyc.size() == 16) ? s_acc_cyc[15] - s_acc_cyc[8] : -1);
    end
    checks++;
    if (s_fd_cnt != 1 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_done frame_done count %0d err %b expected 1 and 0", s_fd_cnt, s_err);
    end
  endtask

  task automatic test_coincident_done();
    logic [7:0] info, par;
    info = 8'($urandom);
    par  = 8'($urandom);
    drive_frame_s(info, par, 2, 0, 0, -1);
    checks++;
    if (s_got.size() != 16 || pack16() !== {info, par}) begin
      errors++;
      $display("FAIL coinc_stream got %b expected %b", pack16(), {info, par});
    end
    checks++;
    if (s_acc_cyc.size() != 16 || s_acc_cyc[8] - s_acc_cyc[7] != 1) begin
      errors++;
      $display("FAIL coinc_gap gap between info bit 8 and parity bit 1 is %0d expected 1",
               (s_acc_cyc.size() == 16) ? s_acc_cyc[8] - s_acc_cyc[7] : -1);
    end
    checks++;
    if (s_fd_cnt != 1 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL coinc_done frame_done count %0d err %b expected 1 and 0", s_fd_cnt, s_err);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] info, par;
    int         mode;
    bit         bp;
    for (int t = 0; t < 4; t++) begin
      info = 8'($urandom);
      par  = 8'($urandom);
      mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      bp   = bit'($urandom_range(0, 1));
      drive_frame_s(info, par, mode, bp, 1, -1);
      checks++;
      if (s_got.size() != 16 || pack16() !== {info, par}) begin
        errors++;
        $display("FAIL rand_stream[%0d] got %b expected %b", t, pack16(), {info, par});
      end
      checks++;
      if (s_fd_cnt != 1) begin
        errors++;
        $display("FAIL rand_done[%0d] frame_done count %0d expected 1", t, s_fd_cnt);
      end
      checks++;
      if (s_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_err[%0d] err_sticky=%b expected 0", t, s_err);
      end
    end
  endtask

  task automatic test_early_done();
    logic [7:0] info, par;
    info = 8'($urandom);
    par  = 8'($urandom);
    drive_frame_s(info, par, 1, 0, 0, -1);
    checks++;
    if (s_err !== 1'b1) begin
      errors++;
      $display("FAIL early_err err_sticky=%b expected 1", s_err);
    end
    checks++;
    if (s_got.size() != 16 || pack16() !== {info, par}) begin
      errors++;
      $display("FAIL early_stream got %b expected %b", pack16(), {info, par});
    end
    checks++;
    if (s_fd_cnt != 1) begin
      errors++;
      $display("FAIL early_done frame_done count %0d expected 1", s_fd_cnt);
    end
  endtask

  task automatic test_mid_reset();
    drive_frame_s(8'b1011_0010, 8'hC5, 0, 0, 0, 3);
    cyc_s(0, 0, 0, 0, '0, 0, 1);
    checks++;
    if ({s_out_valid, s_out_bit, s_frame_done, s_busy, s_err} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs {valid,bit,done,busy,err}=%b expected 00000",
               {s_out_valid, s_out_bit, s_frame_done, s_busy, s_err});
    end
    repeat (5) cyc_s(0, 0, 0, 0, '0, 0, 1);
    checks++;
    if (s_fd_cnt != 0) begin
      errors++;
      $display("FAIL midreset_no_done frame_done count %0d expected 0", s_fd_cnt);
    end
    drive_frame_s(8'b1011_0010, 8'hC5, 0, 0, 0, -1);
    checks++;
    if (s_got.size() != 16 || pack16() !== 16'b1011_0010_1100_0101) begin
      errors++;
      $display("FAIL midreset_fresh_stream got %b expected 1011001011000101", pack16());
    end
    checks++;
    if (s_fd_cnt != 1 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh_done frame_done count %0d err %b expected 1 and 0", s_fd_cnt, s_err);
    end
  endtask

  task automatic test_full_size();
    logic info[F_INFO];
    logic exp_q[$];
    int   bad, first_bad;
    for (int i = 0; i < F_INFO; i++) info[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < F_PAR; i++) f_pvec[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < F_INFO; i++) exp_q.push_back(info[i]);
    for (int j = 0; j < F_PAR; j++) exp_q.push_back(f_pvec[F_PAR-1-j]);
    f_got.delete();
    f_fd_cnt = 0;
    cyc_f(1, 0, 0, 0, 1);
    for (int i = 0; i < F_INFO; i++) begin
      if ($urandom_range(0, 7) == 0) cyc_f(0, 0, 0, 0, 1);
      cyc_f(0, info[i], 1, 0, 1);
    end
    cyc_f(0, 0, 0, 0, 1);
    cyc_f(0, 0, 0, 1, 1);
    for (int n = 0; n < 20000 && f_fd_cnt == 0; n++) begin
      cyc_f(0, 0, 0, 0, (f_got.size() < F_INFO) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
    checks++;
    if (f_got.size() != F_INFO + F_PAR) begin
      errors++;
      $display("FAIL full_length got %0d bits expected %0d", f_got.size(), F_INFO + F_PAR);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < F_INFO + F_PAR && i < f_got.size(); i++) begin
      if (f_got[i] !== exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_stream %0d bit mismatches (first at %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (f_fd_cnt != 1 || f_err !== 1'b0 || f_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done frame_done count %0d err %b busy %b expected 1, 0, 0", f_fd_cnt, f_err, f_busy);
    end
`ifdef QC_LDPC_SER_FRAME_FLAGS_EN
    checks++;
    if (f_sop_idx != 0 || f_eop_idx != F_INFO + F_PAR - 1) begin
      errors++;
      $display("FAIL full_flags sop at %0d eop at %0d expected 0 and %0d", f_sop_idx, f_eop_idx, F_INFO + F_PAR - 1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_coincident_done();
    test_random_frames();
    test_early_done();
    test_mid_reset();
    test_full_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
